// File: rtl/dna_pkg.sv
// ---------------------------------------------------------------------------
// dna_pkg
// Shared definitions for the seed-lookup / candidate-verification pipeline:
// 2-bit base encoding, default reference index width, the verifier FSM state
// type and a per-base compare helper.
// ---------------------------------------------------------------------------
package dna_pkg;

   localparam int BASE_W = 2;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_G = 2'b01;
   localparam logic [1:0] BASE_C = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   localparam int IDX_W_DEFAULT = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CMP  = 1'b1
   } vstate_t;

   // One when the two encoded bases differ.
   function automatic logic base_differs(input logic [BASE_W-1:0] a,
                                         input logic [BASE_W-1:0] b);
      return (a != b);
   endfunction

endpackage

// File: rtl/cand_fifo.sv
// ---------------------------------------------------------------------------
// cand_fifo
// Synchronous first-word-fall-through FIFO for verifier candidates.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push, wdata  write strobe and data (ignored when full without pop)
//   pop          read strobe (ignored when empty)
//   rdata        head entry, valid while empty is low
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module cand_fifo #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty = (count_q == CNT_W'(0));
   assign full  = (count_q == CNT_W'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   // Qualify strobes against occupancy; a full FIFO accepts a push only alongside a pop.
   always_comb begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
   end

   // Storage array; data needs no reset because occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers and occupancy counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push_s && !do_pop_s) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop_s && !do_push_s) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/candidate_verifier.sv
// ---------------------------------------------------------------------------
// candidate_verifier
// Buffers candidate alignment windows from the k-mer lookup stage and scores
// every offset of the loaded short read inside each window by mismatch count.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   read_load, read_in             capture a new short read (clears best/dedup)
//   cand_valid/index/window        candidate strobe, window base index, window
//   index_done                     upstream lookup finished (level)
//   hit_valid/pos/mm               one-cycle pulse per offset within budget
//   best_valid/pos/mm              lowest-mismatch hit since the last read_load
//   overflow                       sticky: a candidate was dropped on full FIFO
//   done                           sticky: upstream done and all work drained
// ---------------------------------------------------------------------------
module candidate_verifier
   import dna_pkg::*;
#(
   parameter int READ_BASES = 8,
   parameter int WIN_BASES  = 10,
   parameter int IDX_W      = IDX_W_DEFAULT,
   parameter int MAX_MM     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         read_load,
   input  logic [BASE_W*READ_BASES-1:0] read_in,
   input  logic                         cand_valid,
   input  logic [IDX_W-1:0]             cand_index,
   input  logic [BASE_W*WIN_BASES-1:0]  cand_window,
   input  logic                         index_done,
   output logic                         hit_valid,
   output logic [IDX_W-1:0]             hit_pos,
   output logic [3:0]                   hit_mm,
   output logic                         best_valid,
   output logic [IDX_W-1:0]             best_pos,
   output logic [3:0]                   best_mm,
   output logic                         overflow,
   output logic                         done
);

   localparam int NOFF    = WIN_BASES - READ_BASES + 1;
   localparam int OFF_W   = (NOFF > 1) ? $clog2(NOFF) : 1;
   localparam int READ_W  = BASE_W * READ_BASES;
   localparam int WIN_W   = BASE_W * WIN_BASES;
   localparam int ENTRY_W = IDX_W + WIN_W;

   vstate_t            state_q;
   logic [OFF_W-1:0]   offset_q;
   logic [IDX_W-1:0]   work_idx_q;
   logic [WIN_W-1:0]   work_win_q;
   logic [READ_W-1:0]  read_q;
   logic               dedup_valid_q;
   logic [IDX_W-1:0]   dedup_idx_q;
   logic               hit_valid_q;
   logic [IDX_W-1:0]   hit_pos_q;
   logic [3:0]         hit_mm_q;
   logic               best_valid_q;
   logic [IDX_W-1:0]   best_pos_q;
   logic [3:0]         best_mm_q;
   logic               overflow_q;
   logic               done_q;

   logic               dup_s;
   logic               push_req_s;
   logic               accept_s;
   logic               drop_s;
   logic               pop_s;
   logic               last_off_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [ENTRY_W-1:0] fifo_rdata_s;
   logic [WIN_W-1:0]   win_shift_s;
   logic [3:0]         mm_s;
   logic               hit_s;
   logic [IDX_W-1:0]   pos_s;
   logic               best_upd_s;
   logic               done_set_s;

   cand_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept_s),
      .wdata ({cand_index, cand_window}),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign last_off_s = (offset_q == OFF_W'(NOFF - 1));

   // Candidate admission: duplicate filter, pop request, and push/drop decision.
   always_comb begin
      dup_s      = dedup_valid_q && (cand_index == dedup_idx_q);
      push_req_s = cand_valid && !dup_s;
      if (state_q == ST_IDLE) begin
         pop_s = !fifo_empty_s;
      end else if (state_q == ST_CMP) begin
         pop_s = last_off_s && !fifo_empty_s;
      end else begin
         pop_s = 1'b0;
      end
      accept_s   = push_req_s && (!fifo_full_s || pop_s);
      drop_s     = push_req_s && fifo_full_s && !pop_s;
      done_set_s = index_done && fifo_empty_s && (state_q == ST_IDLE) && !accept_s;
   end

   // Parallel base compare of the read against the window slice at the current offset.
   always_comb begin
      win_shift_s = work_win_q >> {offset_q, 1'b0};
      mm_s        = 4'd0;
      for (int b = 0; b < READ_BASES; b++) begin
         mm_s = mm_s + 4'(base_differs(read_q[BASE_W*b +: BASE_W],
                                       win_shift_s[BASE_W*b +: BASE_W]));
      end
      hit_s      = (state_q == ST_CMP) && (mm_s <= 4'(MAX_MM));
      pos_s      = work_idx_q + IDX_W'({offset_q, 1'b0});
      best_upd_s = hit_s && (!best_valid_q || (mm_s < best_mm_q));
   end

   // Verifier FSM: loads candidates from the FIFO and steps through the offsets.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         offset_q   <= {OFF_W{1'b0}};
         work_idx_q <= {IDX_W{1'b0}};
         work_win_q <= {WIN_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop_s) begin
                  state_q    <= ST_CMP;
                  offset_q   <= {OFF_W{1'b0}};
                  work_idx_q <= fifo_rdata_s[ENTRY_W-1:WIN_W];
                  work_win_q <= fifo_rdata_s[WIN_W-1:0];
               end
            end
            ST_CMP: begin
               if (!last_off_s) begin
                  offset_q <= offset_q + OFF_W'(1);
               end else if (pop_s) begin
                  // Back-to-back candidate: restart offsets without a bubble.
                  offset_q   <= {OFF_W{1'b0}};
                  work_idx_q <= fifo_rdata_s[ENTRY_W-1:WIN_W];
                  work_win_q <= fifo_rdata_s[WIN_W-1:0];
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Hit reporting, running best, read and dedup registers, sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_valid_q   <= 1'b0;
         hit_pos_q     <= {IDX_W{1'b0}};
         hit_mm_q      <= 4'd0;
         best_valid_q  <= 1'b0;
         best_pos_q    <= {IDX_W{1'b0}};
         best_mm_q     <= 4'd0;
         read_q        <= {READ_W{1'b0}};
         dedup_valid_q <= 1'b0;
         dedup_idx_q   <= {IDX_W{1'b0}};
         overflow_q    <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         hit_valid_q <= hit_s;
         if (hit_s) begin
            hit_pos_q <= pos_s;
            hit_mm_q  <= mm_s;
         end
         if (read_load) begin
            read_q        <= read_in;
            best_valid_q  <= 1'b0;
            best_pos_q    <= {IDX_W{1'b0}};
            best_mm_q     <= 4'd0;
            dedup_valid_q <= 1'b0;
         end else begin
            if (best_upd_s) begin
               best_valid_q <= 1'b1;
               best_pos_q   <= pos_s;
               best_mm_q    <= mm_s;
            end
            if (accept_s) begin
               dedup_valid_q <= 1'b1;
               dedup_idx_q   <= cand_index;
            end
         end
         if (drop_s) begin
            overflow_q <= 1'b1;
         end
         if (done_set_s) begin
            done_q <= 1'b1;
         end
      end
   end

   assign hit_valid  = hit_valid_q;
   assign hit_pos    = hit_pos_q;
   assign hit_mm     = hit_mm_q;
   assign best_valid = best_valid_q;
   assign best_pos   = best_pos_q;
   assign best_mm    = best_mm_q;
   assign overflow   = overflow_q;
   assign done       = done_q;

endmodule

// File: tb/tb_candidate_verifier.sv
// ---------------------------------------------------------------------------
// tb_candidate_verifier
// Directed and randomized stimulus for candidate_verifier, checked against a
// behavioural model that scores each accepted candidate straight from the
// read/window contents and keeps the expected hit list and running best.
// ---------------------------------------------------------------------------
module tb_candidate_verifier;

   localparam int RB     = 8;
   localparam int WB     = 10;
   localparam int NOFF   = WB - RB + 1;
   localparam int MAX_MM = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_load;
   logic [15:0] read_in;
   logic        cand_valid;
   logic [7:0]  cand_index;
   logic [19:0] cand_window;
   logic        index_done;
   logic        hit_valid;
   logic [7:0]  hit_pos;
   logic [3:0]  hit_mm;
   logic        best_valid;
   logic [7:0]  best_pos;
   logic [3:0]  best_mm;
   logic        overflow;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   logic [15:0] m_read;
   bit          m_dv;
   logic [7:0]  m_last;
   bit          m_bv;
   logic [7:0]  m_bpos;
   logic [3:0]  m_bmm;
   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];

   always #5 clk = ~clk;

   candidate_verifier dut (
      .clk         (clk),
      .reset       (reset),
      .read_load   (read_load),
      .read_in     (read_in),
      .cand_valid  (cand_valid),
      .cand_index  (cand_index),
      .cand_window (cand_window),
      .index_done  (index_done),
      .hit_valid   (hit_valid),
      .hit_pos     (hit_pos),
      .hit_mm      (hit_mm),
      .best_valid  (best_valid),
      .best_pos    (best_pos),
      .best_mm     (best_mm),
      .overflow    (overflow),
      .done        (done)
   );

   // collect every hit pulse
   always @(negedge clk) begin
      if (hit_valid === 1'b1) obs_q.push_back({hit_pos, hit_mm});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int count_mm(input logic [15:0] rd, input logic [19:0] win, input int k);
      int m;
      m = 0;
      for (int b = 0; b < RB; b++) begin
         if (rd[2*b +: 2] != win[2*(k+b) +: 2]) m++;
      end
      return m;
   endfunction

   task automatic model_reset();
      m_read = 16'h0000; m_dv = 1'b0; m_last = 8'h00;
      m_bv = 1'b0; m_bpos = 8'h00; m_bmm = 4'h0;
      exp_q.delete();
   endtask

   task automatic model_push(input logic [7:0] idx, input logic [19:0] win);
      int m;
      logic [7:0] p;
      if (m_dv && idx == m_last) return;
      m_dv = 1'b1;
      m_last = idx;
      for (int k = 0; k < NOFF; k++) begin
         m = count_mm(m_read, win, k);
         if (m <= MAX_MM) begin
            p = idx + 8'(2*k);
            exp_q.push_back({p, 4'(m)});
            if (!m_bv || m < int'(m_bmm)) begin
               m_bv = 1'b1; m_bpos = p; m_bmm = 4'(m);
            end
         end
      end
   endtask

   function automatic logic [19:0] make_win(input logic [15:0] rd);
      logic [19:0] w;
      int k;
      int b;
      w = 20'($urandom);
      if ($urandom_range(0, 3) != 0) begin
         k = $urandom_range(0, NOFF-1);
         w[2*k +: 16] = rd;
         if ($urandom_range(0, 1) == 1) begin
            b = $urandom_range(0, RB-1);
            w[2*(k+b) +: 2] = w[2*(k+b) +: 2] ^ 2'($urandom_range(1, 3));
         end
      end
      return w;
   endfunction

   task automatic do_load(input logic [15:0] v);
      @(negedge clk);
      read_load = 1'b1; read_in = v;
      @(negedge clk);
      read_load = 1'b0;
      m_read = v; m_dv = 1'b0; m_bv = 1'b0;
      chk("load best cleared", best_valid, 1'b0);
   endtask

   task automatic send(input logic [7:0] idx, input logic [19:0] win);
      model_push(idx, win);
      @(negedge clk);
      cand_valid = 1'b1; cand_index = idx; cand_window = win;
      @(negedge clk);
      cand_valid = 1'b0;
   endtask

   task automatic compare_hits(input string tag);
      chk({tag, " hit count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk({tag, " hit"}, obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_best(input string tag);
      chk({tag, " best_valid"}, best_valid, m_bv);
      if (m_bv) begin
         chk({tag, " best_pos"}, best_pos, m_bpos);
         chk({tag, " best_mm"}, best_mm, m_bmm);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " hit_valid"}, hit_valid, 1'b0);
      chk({tag, " hit_pos"}, hit_pos, 8'h00);
      chk({tag, " hit_mm"}, hit_mm, 4'h0);
      chk({tag, " best_valid"}, best_valid, 1'b0);
      chk({tag, " best_pos"}, best_pos, 8'h00);
      chk({tag, " best_mm"}, best_mm, 4'h0);
      chk({tag, " overflow"}, overflow, 1'b0);
      chk({tag, " done"}, done, 1'b0);
   endtask

   initial begin
      logic [7:0]  idx;
      logic [19:0] win;
      int          last_hit;
      int          first_done;

      reset = 1'b1; read_load = 1'b0; read_in = 16'h0000;
      cand_valid = 1'b0; cand_index = 8'h00; cand_window = 20'h00000; index_done = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // exact match with latency check
      do_load(16'h1B2D);
      model_push(8'd20, 20'h01B2D);
      @(negedge clk);
      cand_valid = 1'b1; cand_index = 8'd20; cand_window = 20'h01B2D;
      @(negedge clk);
      cand_valid = 1'b0;
      chk("exact E0 no hit", hit_valid, 1'b0);
      @(negedge clk);
      chk("exact E1 no hit", hit_valid, 1'b0);
      @(negedge clk);
      chk("exact E2 hit_valid", hit_valid, 1'b1);
      chk("exact E2 hit_pos", hit_pos, 8'd20);
      chk("exact E2 hit_mm", hit_mm, 4'd0);
      chk("exact E2 best_pos", best_pos, 8'd20);
      chk("exact E2 best_mm", best_mm, 4'd0);
      repeat (8) @(negedge clk);
      compare_hits("exact");
      check_best("exact");

      // shifted match, budget, no-hit window
      send(8'd40, 20'h06CB4);
      repeat (8) @(negedge clk);
      compare_hits("shift");
      check_best("shift");
      send(8'd20, 20'h01B2C);
      repeat (8) @(negedge clk);
      compare_hits("budget");
      send(8'd60, 20'h00000);
      repeat (8) @(negedge clk);
      compare_hits("nohit");
      check_best("nohit");

      // dedup: same index on three consecutive cycles
      model_push(8'd20, 20'h01B2D);
      @(negedge clk);
      cand_valid = 1'b1; cand_index = 8'd20; cand_window = 20'h01B2D;
      repeat (3) @(negedge clk);
      cand_valid = 1'b0;
      repeat (10) @(negedge clk);
      compare_hits("dedup");
      chk("dedup overflow", overflow, 1'b0);

      // randomized candidates, spaced to avoid overflow
      for (int r = 0; r < 3; r++) begin
         do_load(16'($urandom));
         for (int n = 0; n < 15; n++) begin
            idx = 8'(2 * $urandom_range(0, 5));
            win = make_win(m_read);
            send(idx, win);
            repeat ($urandom_range(NOFF, NOFF + 2)) @(negedge clk);
         end
         repeat (12) @(negedge clk);
         compare_hits("rand");
         check_best("rand");
         chk("rand overflow", overflow, 1'b0);
      end

      // overflow: seven distinct back-to-back candidates
      do_load(16'($urandom));
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         idx = 8'(100 + 2*i);
         win = make_win(m_read);
         if (i < 6) model_push(idx, win);
         cand_valid = 1'b1; cand_index = idx; cand_window = win;
         @(negedge clk);
      end
      cand_valid = 1'b0;
      chk("overflow set", overflow, 1'b1);
      repeat (30) @(negedge clk);
      compare_hits("ovf");
      check_best("ovf");

      // completion only after queued work drains
      chk("done before", done, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         idx = 8'(150 + 2*i);
         win = {4'($urandom), m_read};
         model_push(idx, win);
         cand_valid = 1'b1; cand_index = idx; cand_window = win;
         @(negedge clk);
      end
      cand_valid = 1'b0;
      index_done = 1'b1;
      chk("done not early", done, 1'b0);
      last_hit = -1;
      first_done = -1;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (hit_valid === 1'b1) last_hit = t;
         if (done === 1'b1 && first_done < 0) first_done = t;
      end
      chk("done rose", first_done >= 0, 1'b1);
      chk("done after last hit", first_done > last_hit, 1'b1);
      compare_hits("drain");

      // reset in the middle of a compare
      index_done = 1'b0;
      @(negedge clk);
      cand_valid = 1'b1; cand_index = 8'd200; cand_window = {4'h0, m_read};
      @(negedge clk);
      cand_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_zero("midreset");
      model_reset();
      obs_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("midreset no hits", obs_q.size(), 0);
      chk("midreset done", done, 1'b0);
      chk("midreset best_valid", best_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
